bram_wave_player: RTL and testbench
===================================

// Module: bram_wave_player
// PURPOSE
//  Multi-channel BRAM waveform sequencer for the signal generator. Reads N_CH parallel BRAMs
//  over a shared address window [start_addr..end_addr] at a decimated rate, in one-shot,
//  continuous or N-repeat mode, and drives DAC-side sample outputs with a valid strobe.
//  Outputs per-channel default values while idle. Handles BRAM read latency internally.
// PARAMETERS
//  ADDR_WIDTH  8   BRAM address width; the address counter wraps modulo 2^ADDR_WIDTH
//  DATA_WIDTH  14  sample width per channel
//  N_CH        2   channel count; all channels share one address
//  RD_LAT      1   BRAM read latency in clk cycles, 1..4
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous, active-high reset
//  en             in   1              start; acts on rising edge only
//  stop           in   1              abort; level, sampled each cycle
//  mode           in   2              0 one-shot, 1 continuous, 2 repeat, 3 treated as one-shot
//  repeat_count   in   16             number of passes in repeat mode
//  dec_rate       in   32             hold each address for dec_rate+1 cycles
//  start_addr     in   ADDR_WIDTH     first address of the window
//  end_addr       in   ADDR_WIDTH     last address of the window, inclusive
//  default_value  in   N_CH*DATA_WIDTH  idle output; ch k at bits [k*DW +: DW]
//  bram_addr      out  ADDR_WIDTH     shared read address
//  bram_en        out  1              read strobe; 1 on first cycle of each address
//  bram_we        out  1              always 0
//  bram_data_i    in   N_CH*DATA_WIDTH  BRAM read data, packed like default_value
//  data_o         out  N_CH*DATA_WIDTH  registered sample output
//  data_valid     out  1              1 for one cycle per new sample on data_o
//  busy           out  1              1 in RUN or FLUSH
//  wrap           out  1              1-cycle pulse when the address reloads start_addr for a new pass
//  done           out  1              1-cycle pulse on the FLUSH->IDLE transition
// BEHAVIOUR
//  Reset: FSM=IDLE; bram_addr=0; bram_en=0; data_o=0; data_valid/busy/wrap/done=0; dec counter=0;
//   pass counter=0; delay line cleared. On the first idle cycle after reset, data_o=default_value.
//  Config latching: mode, repeat_count, dec_rate, start_addr and end_addr are latched on the start edge.
//   Later input changes have no effect until the next start edge.
//  Pass count: passes = max(1, repeat_count) in repeat mode; 1 in one-shot mode; unbounded in continuous mode.
//  FSM:
//   IDLE -(en rise)-> RUN, with bram_addr=start_addr and bram_en=1 in the first RUN cycle.
//   RUN: dec counter counts 0..dec_rate. At dec_rate the counter resets and the address advances.
//    The address steps +1 modulo 2^ADDR_WIDTH. If end_addr < start_addr the window wraps through 0.
//    If start_addr == end_addr the window is a single sample.
//   Leaving end_addr, in order of precedence:
//    - passes remain or mode is continuous: addr<=start_addr, wrap=1 for that cycle.
//    - final pass complete: go to FLUSH.
//   RUN -(stop)-> FLUSH immediately; no further bram_en is issued.
//   FLUSH: lasts RD_LAT+1 cycles so in-flight reads still emit data_valid, then goes to IDLE with done=1.
//   en rise while busy: restart. Config is relatched, addr=start_addr, and the state goes to RUN.
//    In-flight samples still emit. done is not pulsed.
//   stop and en rise in the same cycle: stop wins.
//   rst at any time: return to reset state next cycle. No done pulse.
//  Latency: a bram_en issued in cycle t produces data_o=bram_data_i and data_valid=1 in cycle t+RD_LAT+1.
//   A delay line of length RD_LAT+1 carries the strobe.
//  Output hold: data_o holds the last sample between valids.
//   When IDLE with an empty pipe, data_o is reloaded from default_value every cycle.
//  Arithmetic: dec counter is 32-bit, compared with ==. The pass counter is 16-bit.
//   dec_rate=0 gives one sample per clk, with bram_en and data_valid continuously high.
// STRUCTURE
//  bram_player_pkg: mode localparams MODE_ONESHOT/CONTINUOUS/REPEAT, FSM state encodings
//   (IDLE/RUN/FLUSH), RD_LAT range check.
//  Sub-module valid_delay_line #(DEPTH): a clearable shift register for the read strobe.
//  All other logic is in this file: edge detect, config latch, FSM, address/dec/pass counters, output register.
// TESTING (mem[a]=a+100 per ch0, a+200 per ch1; RD_LAT=1, ADDR_WIDTH=8 unless stated)
//  1 One-shot start=4 end=7 dec=0 -> 4 consecutive valids, ch0 104..107; done 1 cycle after the last; then data_o=default.
//  2 One-shot start=0 end=2 dec=2 -> bram_en every 3 cycles; valid 2 cycles after each; 3 samples total.
//  3 Repeat, repeat_count=3, start=10 end=11 -> ch0 110,111 x3; wrap pulses 2; done 1. repeat_count=0 -> one pass.
//  4 Wrap-around start=254 end=1 -> addresses 254,255,0,1; single-sample start=end=5 -> one valid.
//  5 Continuous start=0 end=3 -> loops until stop; stop -> <=RD_LAT+1 trailing valids, then done; stop+en in same cycle -> stop wins.
//  6 en re-rise mid-run -> restart at the new start_addr without a done pulse; rst mid-run -> all outputs at reset values next cycle; RD_LAT=3 repeats test 1 with valid delayed 2 cycles.

Source files
------------

// File: rtl/bram_player_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bram_player_pkg
// Purpose  : shared mode codes, FSM states and read-latency bounds for the player
// Revision : 1.0 - initial release
// ============================================================================
package bram_player_pkg;

  localparam logic [1:0] MODE_ONESHOT    = 2'd0;
  localparam logic [1:0] MODE_CONTINUOUS = 2'd1;
  localparam logic [1:0] MODE_REPEAT     = 2'd2;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : valid_delay_line
// Purpose  : clearable shift register carrying the BRAM read strobe
// Revision : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_i,
  output logic [DEPTH-1:0] taps_o
);

  logic [DEPTH-1:0] taps_q;

  // Bit k holds the strobe issued k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= DEPTH'({taps_q, strobe_i});
    end
  end

  assign taps_o = taps_q;

endmodule
`default_nettype wire

// File: rtl/bram_wave_player.sv
`default_nettype none
// ============================================================================
// Module   : bram_wave_player
// Purpose  : multi-channel BRAM waveform sequencer with decimation and pass control
// Revision : 1.0 - initial release
// ============================================================================
module bram_wave_player
  import bram_player_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 14,
  parameter int N_CH       = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       stop,
  input  logic [1:0]                 mode,
  input  logic [15:0]                repeat_count,
  input  logic [31:0]                dec_rate,
  input  logic [ADDR_WIDTH-1:0]      start_addr,
  input  logic [ADDR_WIDTH-1:0]      end_addr,
  input  logic [N_CH*DATA_WIDTH-1:0] default_value,
  output logic [ADDR_WIDTH-1:0]      bram_addr,
  output logic                       bram_en,
  output logic                       bram_we,
  input  logic [N_CH*DATA_WIDTH-1:0] bram_data_i,
  output logic [N_CH*DATA_WIDTH-1:0] data_o,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       wrap,
  output logic                       done
);

  localparam int DW = N_CH * DATA_WIDTH;

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
    $error("bram_wave_player: RD_LAT must lie in 1..4");
  end

  state_t                state_q, state_d;
  logic                  en_q;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           rc_q, rc_d;
  logic [31:0]           dec_rate_q, dec_rate_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           dec_q, dec_d;
  logic [15:0]           pass_q, pass_d;
  logic [2:0]            flush_q, flush_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic [DW-1:0]         data_q, data_d;

  logic [RD_LAT:0]       taps;
  logic [15:0]           passes;
  logic                  start_go;
  logic                  rd_strobe;
  logic                  more_passes;

  // stop outranks a simultaneous start edge in every state.
  assign start_go  = en & ~en_q & ~stop;
  assign rd_strobe = (state_q == ST_RUN) && (dec_q == 32'd0) && !stop;

  always_comb begin
    passes = 16'd1;
    case (mode_q)
      MODE_REPEAT: passes = (rc_q == 16'd0) ? 16'd1 : rc_q;
      default:     passes = 16'd1;
    endcase
  end

  assign more_passes = (mode_q == MODE_CONTINUOUS) || (pass_q != passes - 16'd1);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rc_d       = rc_q;
    dec_rate_d = dec_rate_q;
    start_d    = start_q;
    end_d      = end_q;
    addr_d     = addr_q;
    dec_d      = dec_q;
    pass_d     = pass_q;
    flush_d    = flush_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;

    if (start_go) begin
      mode_d     = (mode == 2'd3) ? MODE_ONESHOT : mode;
      rc_d       = repeat_count;
      dec_rate_d = dec_rate;
      start_d    = start_addr;
      end_d      = end_addr;
      addr_d     = start_addr;
      dec_d      = 32'd0;
      pass_d     = 16'd0;
      flush_d    = 3'd0;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (stop) begin
            state_d = ST_FLUSH;
            flush_d = 3'd0;
          end else if (dec_q == dec_rate_q) begin
            dec_d = 32'd0;
            if (addr_q == end_q) begin
              if (more_passes) begin
                addr_d = start_q;
                wrap_d = 1'b1;
                if (mode_q != MODE_CONTINUOUS) pass_d = pass_q + 16'd1;
              end else begin
                state_d = ST_FLUSH;
                flush_d = 3'd0;
              end
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            dec_d = dec_q + 32'd1;
          end
        end
        ST_FLUSH: begin
          // RD_LAT+1 cycles drains every strobe still in the delay line.
          if (flush_q == 3'(RD_LAT)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            flush_d = flush_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    data_d = data_q;
    if (taps[RD_LAT-1]) begin
      data_d = bram_data_i;
    end else if ((state_q == ST_IDLE) && !(|taps)) begin
      data_d = default_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= MODE_ONESHOT;
      rc_q       <= 16'd0;
      dec_rate_q <= 32'd0;
      start_q    <= '0;
      end_q      <= '0;
      addr_q     <= '0;
      dec_q      <= 32'd0;
      pass_q     <= 16'd0;
      flush_q    <= 3'd0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en;
      mode_q     <= mode_d;
      rc_q       <= rc_d;
      dec_rate_q <= dec_rate_d;
      start_q    <= start_d;
      end_q      <= end_d;
      addr_q     <= addr_d;
      dec_q      <= dec_d;
      pass_q     <= pass_d;
      flush_q    <= flush_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  valid_delay_line #(
    .DEPTH(RD_LAT + 1)
  ) u_valid_dly (
    .clk     (clk),
    .rst     (rst),
    .strobe_i(rd_strobe),
    .taps_o  (taps)
  );

  assign bram_addr  = addr_q;
  assign bram_en    = rd_strobe;
  assign bram_we    = 1'b0;
  assign data_o     = data_q;
  assign data_valid = taps[RD_LAT];
  assign busy       = (state_q != ST_IDLE);
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_wave_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_wave_player
// Purpose  : scoreboard bench for bram_wave_player (RD_LAT=1 and RD_LAT=3 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_wave_player;

  localparam logic [27:0] DEF = {14'd777, 14'd555};

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] repeat_count = 16'd0;
  logic [31:0] dec_rate = 32'd0;
  logic [7:0]  start_addr = 8'd0, end_addr = 8'd0;
  logic [27:0] default_value = DEF;

  logic [7:0]  addr1, addr3, a1_q, b1_q, b2_q, b3_q;
  logic        en1, we1, valid1, busy1, wrap1, done1;
  logic        en3, we3, valid3, busy3, wrap3, done3;
  logic [27:0] rdata1, rdata3, data1, data3;

  always #5 clk = ~clk;

  function automatic logic [27:0] mem(input logic [7:0] a);
    return {14'(a) + 14'd200, 14'(a) + 14'd100};
  endfunction

  // Synchronous BRAM models with one and three cycles of read latency.
  always @(posedge clk) begin
    a1_q <= addr1;
    b1_q <= addr3; b2_q <= b1_q; b3_q <= b2_q;
  end
  assign rdata1 = mem(a1_q);
  assign rdata3 = mem(b3_q);

  bram_wave_player #(.ADDR_WIDTH(8), .DATA_WIDTH(14), .N_CH(2), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .mode(mode), .repeat_count(repeat_count),
    .dec_rate(dec_rate), .start_addr(start_addr), .end_addr(end_addr),
    .default_value(default_value), .bram_addr(addr1), .bram_en(en1), .bram_we(we1),
    .bram_data_i(rdata1), .data_o(data1), .data_valid(valid1), .busy(busy1),
    .wrap(wrap1), .done(done1));

  bram_wave_player #(.ADDR_WIDTH(8), .DATA_WIDTH(14), .N_CH(2), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .mode(mode), .repeat_count(repeat_count),
    .dec_rate(dec_rate), .start_addr(start_addr), .end_addr(end_addr),
    .default_value(default_value), .bram_addr(addr3), .bram_en(en3), .bram_we(we3),
    .bram_data_i(rdata3), .data_o(data3), .data_valid(valid3), .busy(busy3),
    .wrap(wrap3), .done(done3));

  int errors = 0, checks = 0, cyc = 0;
  int en_cnt, valid_cnt, wrap_cnt, done_cnt, gap_err, done_gap, gap_exp;
  int last_en, last_valid, first1, first3;
  logic [13:0] first_s;
  bit have_last, gap_chk, chk3;
  logic [27:0] sc_q[$];
  int          stamp_q[$];
  logic [27:0] cap3[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples at the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (en1) begin
        en_cnt++;
        stamp_q.push_back(cyc);
        if (gap_chk && have_last && (cyc - last_en) != gap_exp) gap_err++;
        last_en   = cyc;
        have_last = 1'b1;
      end
      if (wrap1) wrap_cnt++;
      if (done1) begin
        done_cnt++;
        done_gap = cyc - last_valid;
      end
      if (valid1) begin
        if (valid_cnt == 0) begin
          first1  = cyc;
          first_s = data1[13:0];
        end
        valid_cnt++;
        last_valid = cyc;
        if (sc_q.size() == 0 || stamp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: data_o=%0h with no expected sample or read", data1);
        end else begin
          chk("sample", data1, sc_q.pop_front());
          chk("latency", cyc - stamp_q.pop_front(), 2);
        end
      end
      if (chk3 && valid3) begin
        if (cap3.size() == 0) first3 = cyc;
        cap3.push_back(data3);
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] rc;
    logic [31:0] dec;
    logic [7:0]  s;
    logic [7:0]  e;
    int          n_valid;
    int          n_wrap;
    int          first;
  } vec_t;

  vec_t vecs[8];

  task automatic clear_counts();
    en_cnt = 0; valid_cnt = 0; wrap_cnt = 0; done_cnt = 0; gap_err = 0;
    have_last = 1'b0; done_gap = -1; first_s = '0;
  endtask

  task automatic start_pulse();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) tick();
  endtask

  task automatic push_window(input logic [1:0] m, input logic [15:0] rc,
                             input logic [7:0] s, input logic [7:0] e);
    int np;
    logic [7:0] a;
    np = (m == 2'd2) ? ((rc == 16'd0) ? 1 : int'(rc)) : 1;
    for (int p = 0; p < np; p++) begin
      a = s;
      for (int k = 0; k < 256; k++) begin
        sc_q.push_back(mem(a));
        if (a == e) break;
        a = a + 8'd1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    clear_counts();
    gap_chk = 1'b1;
    gap_exp = int'(v.dec) + 1;
    mode = v.mode; repeat_count = v.rc; dec_rate = v.dec;
    start_addr = v.s; end_addr = v.e;
    push_window(v.mode, v.rc, v.s, v.e);
    start_pulse();
    chk($sformatf("v%0d_busy_running", idx), busy1, 1);
    // Scramble the config inputs; the run must keep its latched copy.
    mode = 2'd1; repeat_count = 16'd9; dec_rate = 32'd7; start_addr = 8'd77; end_addr = 8'd66;
    wait_done(4000);
    repeat (6) tick();
    chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
    chk($sformatf("v%0d_valid_count", idx), valid_cnt, v.n_valid);
    chk($sformatf("v%0d_wrap_count", idx), wrap_cnt, v.n_wrap);
    chk($sformatf("v%0d_first_ch0", idx), first_s, v.first);
    chk($sformatf("v%0d_leftover", idx), sc_q.size(), 0);
    chk($sformatf("v%0d_en_spacing_errs", idx), gap_err, 0);
    chk($sformatf("v%0d_done_after_last", idx), done_gap, int'(v.dec) + 1);
    chk($sformatf("v%0d_idle_busy", idx), busy1, 0);
    chk($sformatf("v%0d_idle_default", idx), data1, DEF);
    gap_chk = 1'b0;
    sc_q.delete();
  endtask

  int snap;

  initial begin
    //          mode   rc     dec    s       e      n  wr first
    vecs[0] = '{2'd0, 16'd0, 32'd0, 8'd4,   8'd7,   4, 0, 104};
    vecs[1] = '{2'd0, 16'd0, 32'd2, 8'd0,   8'd2,   3, 0, 100};
    vecs[2] = '{2'd2, 16'd3, 32'd0, 8'd10,  8'd11,  6, 2, 110};
    vecs[3] = '{2'd2, 16'd0, 32'd0, 8'd10,  8'd11,  2, 0, 110};
    vecs[4] = '{2'd0, 16'd0, 32'd0, 8'd254, 8'd1,   4, 0, 354};
    vecs[5] = '{2'd0, 16'd0, 32'd1, 8'd5,   8'd5,   1, 0, 105};
    vecs[6] = '{2'd3, 16'd0, 32'd0, 8'd2,   8'd3,   2, 0, 102};
    vecs[7] = '{2'd2, 16'd2, 32'd1, 8'd255, 8'd0,   4, 1, 355};
    gap_chk = 1'b0; chk3 = 1'b0;
    clear_counts();

    repeat (3) tick();
    chk("reset_ctrl_outputs", {addr1, en1, we1, valid1, busy1, wrap1, done1}, 0);
    chk("reset_data", data1, 0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_default_after_reset", data1, DEF);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start edge with stop in the same idle cycle must be ignored.
    clear_counts();
    en = 1'b1; stop = 1'b1;
    tick();
    en = 1'b0; stop = 1'b0;
    repeat (4) tick();
    chk("idle_stop_wins_busy", busy1, 0);
    chk("idle_stop_wins_reads", en_cnt, 0);

    // Continuous loop, then stop together with a fresh start edge.
    clear_counts();
    gap_chk = 1'b1; gap_exp = 1;
    mode = 2'd1; repeat_count = 16'd0; dec_rate = 32'd0; start_addr = 8'd0; end_addr = 8'd3;
    for (int k = 0; k < 40; k++) sc_q.push_back(mem(8'(k % 4)));
    start_pulse();
    for (int i = 0; i < 200 && valid_cnt < 10; i++) tick();
    chk("cont_running", busy1, 1);
    snap = valid_cnt;
    en = 1'b1; stop = 1'b1;
    tick();
    en = 1'b0; stop = 1'b0;
    wait_done(50);
    repeat (6) tick();
    chk("cont_done", done_cnt, 1);
    chk("cont_trailing_le_2", (valid_cnt - snap) <= 2, 1);
    chk("cont_wraps_ge_2", wrap_cnt >= 2, 1);
    chk("cont_reads_drained", stamp_q.size(), 0);
    chk("cont_idle", busy1, 0);
    gap_chk = 1'b0;
    sc_q.delete();

    // Restart mid-run at a new window: no done from the abandoned run.
    clear_counts();
    mode = 2'd0; dec_rate = 32'd0; start_addr = 8'd0; end_addr = 8'd7;
    for (int k = 0; k < 3; k++) sc_q.push_back(mem(8'(k)));
    for (int k = 20; k < 23; k++) sc_q.push_back(mem(8'(k)));
    start_pulse();
    tick(); tick();
    start_addr = 8'd20; end_addr = 8'd22;
    start_pulse();
    wait_done(100);
    repeat (6) tick();
    chk("restart_done_count", done_cnt, 1);
    chk("restart_valid_count", valid_cnt, 6);
    chk("restart_leftover", sc_q.size(), 0);
    chk("restart_idle", busy1, 0);

    // Reset in the middle of a run.
    clear_counts();
    mode = 2'd0; start_addr = 8'd0; end_addr = 8'd50;
    for (int k = 0; k < 10; k++) sc_q.push_back(mem(8'(k)));
    start_pulse();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ctrl_outputs", {addr1, en1, valid1, busy1, wrap1, done1}, 0);
    chk("rst_mid_data", data1, 0);
    rst = 1'b0;
    sc_q.delete(); stamp_q.delete();
    tick(); tick();
    chk("rst_release_default", data1, DEF);
    chk("rst_release_busy", busy1, 0);

    // RD_LAT=3 instance repeats the first vector: same samples, two cycles later.
    cap3.delete();
    chk3 = 1'b1;
    run_vec(vecs[0], 8);
    chk3 = 1'b0;
    chk("rl3_count", cap3.size(), 4);
    for (int i = 0; i < 4 && i < cap3.size(); i++)
      chk($sformatf("rl3_sample%0d", i), cap3[i], mem(8'(4 + i)));
    chk("rl3_extra_delay", first3 - first1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
